uart_reg_cmd_rx: RTL

//  UART 8N1 receiver plus ASCII command parser. Host-side counterpart of the register dump transmitter.

---
 rtl/uart_reg_cmd_rx.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_reg_cmd_rx.sv
// uart_reg_cmd_rx: UART receiver with a parser for "W<d>=<hhhh>" lines that issues register write strobes.
// The frame is 8N1 by default. Defining UART_RX_PARITY_EN switches it to 8E1, with an even-parity bit
// after the data bits. A bad parity bit is handled like a framing error.
module uart_reg_cmd_rx #(
    parameter int CLK_HZ = 27_000_000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        rx_byte_valid,
    output logic [7:0]  rx_byte,
    output logic        wr_en,
    output logic [2:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        cmd_err
);
    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef UART_RX_PARITY_EN
        , PAR
`endif
    } rx_t;

    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_EQ, P_HEX, P_EOL, P_SKIP} p_t;

    logic          sync_q, rxs;
    rx_t           rx_q, rx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          byte_ok, frame_err, tick;
    logic          vld_q, fe_q;
    logic [7:0]    byte_q;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
`endif

    p_t            p_q, p_d;
    logic [2:0]    idx_q, idx_d;
    logic [15:0]   val_q, val_d;
    logic [1:0]    nib_q, nib_d;
    logic          wr_en_q, wr_en_d, err_q, err_d;
    logic [2:0]    wr_addr_q, wr_addr_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic          is_eol, is_dig, is_hex;
    logic [3:0]    nib;

    assign tick = cnt_q == DIV_M1;

    // Bit-timing FSM: confirm the start bit at half a bit, then sample each later bit at its centre
    always_comb begin
        rx_d      = rx_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        sh_d      = sh_q;
        byte_ok   = 1'b0;
        frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (rx_q)
            IDLE: begin
                cnt_d = '0;
                rx_d  = rxs ? IDLE : START;
            end
            START: if (cnt_q == HALF_M1) begin
                cnt_d = '0;
                bit_d = '0;
                rx_d  = rxs ? IDLE : DATA;
            end
            DATA: if (tick) begin
                cnt_d = '0;
                sh_d  = {rxs, sh_q[7:1]};
                bit_d = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                rx_d  = (bit_q == 3'd7) ? PAR : DATA;
`else
                rx_d  = (bit_q == 3'd7) ? STOP : DATA;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PAR: if (tick) begin
                cnt_d     = '0;
                par_bad_d = rxs ^ (^sh_q);
                rx_d      = STOP;
            end
`endif
            STOP: if (tick) begin
                cnt_d     = '0;
                rx_d      = IDLE;
`ifdef UART_RX_PARITY_EN
                byte_ok   = rxs & ~par_bad_q;
`else
                byte_ok   = rxs;
`endif
                frame_err = ~byte_ok;
            end
            default: rx_d = IDLE;
        endcase
    end

    // Synchroniser, receiver state and the registered byte/error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
            rxs    <= 1'b1;
            rx_q   <= IDLE;
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            vld_q  <= 1'b0;
            fe_q   <= 1'b0;
            byte_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            sync_q <= uart_rx;
            rxs    <= sync_q;
            rx_q   <= rx_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            vld_q  <= byte_ok;
            fe_q   <= frame_err;
            byte_q <= byte_ok ? sh_q : byte_q;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign is_eol = (byte_q == 8'h0D) || (byte_q == 8'h0A);
    assign is_dig = (byte_q >= 8'h30) && (byte_q <= 8'h39);
    assign is_hex = is_dig || ((byte_q >= 8'h41) && (byte_q <= 8'h46)) || ((byte_q >= 8'h61) && (byte_q <= 8'h66));
    assign nib    = is_dig ? byte_q[3:0] : byte_q[3:0] + 4'd9;

    // Line parser: a framing or parity error wins over the byte; any syntax error skips to end of line
    always_comb begin
        p_d       = p_q;
        idx_d     = idx_q;
        val_d     = val_q;
        nib_d     = nib_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = 1'b0;
        if (fe_q) begin
            p_d   = P_SKIP;
            err_d = 1'b1;
        end else if (vld_q) begin
            case (p_q)
                P_IDLE: begin
                    p_d   = (byte_q == 8'h57 || byte_q == 8'h77) ? P_ADDR : is_eol ? P_IDLE : P_SKIP;
                    err_d = p_d == P_SKIP;
                end
                P_ADDR: begin
                    p_d   = (byte_q >= 8'h30 && byte_q <= 8'h37) ? P_EQ : P_SKIP;
                    idx_d = byte_q[2:0];
                    err_d = p_d == P_SKIP;
                end
                P_EQ: begin
                    p_d   = (byte_q == 8'h3D) ? P_HEX : P_SKIP;
                    nib_d = '0;
                    err_d = p_d == P_SKIP;
                end
                P_HEX: begin
                    p_d   = !is_hex ? P_SKIP : (nib_q == 2'd3) ? P_EOL : P_HEX;
                    val_d = {val_q[11:0], nib};
                    nib_d = nib_q + 1'b1;
                    err_d = !is_hex;
                end
                P_EOL: begin
                    p_d       = is_eol ? P_IDLE : P_SKIP;
                    wr_en_d   = is_eol;
                    wr_addr_d = is_eol ? idx_q : wr_addr_q;
                    wr_data_d = is_eol ? val_q : wr_data_q;
                    err_d     = !is_eol;
                end
                default: p_d = is_eol ? P_IDLE : P_SKIP;
            endcase
        end
    end

    // Parser state and the write/error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q       <= P_IDLE;
            idx_q     <= '0;
            val_q     <= '0;
            nib_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            p_q       <= p_d;
            idx_q     <= idx_d;
            val_q     <= val_d;
            nib_q     <= nib_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign rx_byte_valid = vld_q;
    assign rx_byte       = byte_q;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign cmd_err       = err_q;
endmodule
